// File: rtl/rat_dual_dispatch.sv
// rat_dual_dispatch: Register Alias Table and dual-issue dispatch stage.
// This block renames two instructions per cycle (A is older than B) onto the
// ROB tags next_available and next_available+1, and it drives the ROB
// allocate interface. It tracks ROB occupancy and snoops the commit bus so
// that architectural registers return to the committed state.
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   iq_valid / iq_ready        instruction-pair handshake
//   iq_mul_*, iq_rd_*,         opcode (1 = MUL) and architectural register fields
//   iq_rs1_*, iq_rs2_*         of instructions A and B
//   next_available             ROB tail tag
//   ROB_bus_trigger/_tag       commit strobe and committing tag
//   RAT_new_instr              allocate strobe to the ROB
//   new_mul_*, rd_*            opcode and destination passthrough
//   src{1,2}{a,b}[_valid]      renamed sources: {tag, 0} if pending, {arch, 1} if committed
//   rob_count                  in-flight ROB entries, 0..ROB_DEPTH
//   tail_err                   sticky flag: shadow tail disagreed with next_available
//   stall_cnt                  (only with RAT_STALL_STATS_EN) saturating stall-cycle count
//
// Build option: define RAT_STALL_STATS_EN to add the stall_cnt output and counter.

module rat_dual_dispatch #(
    parameter int unsigned NUM_ARCH  = 8,
    parameter int unsigned ROB_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           iq_valid,
    output logic                           iq_ready,
    input  logic                           iq_mul_a,
    input  logic                           iq_mul_b,
    input  logic [$clog2(NUM_ARCH)-1:0]    iq_rd_a,
    input  logic [$clog2(NUM_ARCH)-1:0]    iq_rd_b,
    input  logic [$clog2(NUM_ARCH)-1:0]    iq_rs1_a,
    input  logic [$clog2(NUM_ARCH)-1:0]    iq_rs2_a,
    input  logic [$clog2(NUM_ARCH)-1:0]    iq_rs1_b,
    input  logic [$clog2(NUM_ARCH)-1:0]    iq_rs2_b,
    input  logic [$clog2(ROB_DEPTH)-1:0]   next_available,
    input  logic                           ROB_bus_trigger,
    input  logic [$clog2(ROB_DEPTH)-1:0]   ROB_bus_tag,
    output logic                           RAT_new_instr,
    output logic                           new_mul_a,
    output logic                           new_mul_b,
    output logic [$clog2(NUM_ARCH)-1:0]    rd_a,
    output logic [$clog2(NUM_ARCH)-1:0]    rd_b,
    output logic [$clog2(ROB_DEPTH)-1:0]   src1a,
    output logic [$clog2(ROB_DEPTH)-1:0]   src2a,
    output logic [$clog2(ROB_DEPTH)-1:0]   src1b,
    output logic [$clog2(ROB_DEPTH)-1:0]   src2b,
    output logic                           src1a_valid,
    output logic                           src2a_valid,
    output logic                           src1b_valid,
    output logic                           src2b_valid,
    output logic [$clog2(ROB_DEPTH):0]     rob_count,
`ifdef RAT_STALL_STATS_EN
    output logic [15:0]                    stall_cnt,
`endif
    output logic                           tail_err
);

    localparam int unsigned AW = $clog2(NUM_ARCH);
    localparam int unsigned TW = $clog2(ROB_DEPTH);
    localparam int unsigned CW = TW + 1;

    logic [NUM_ARCH-1:0]         map_valid_q, map_valid_d;
    logic [NUM_ARCH-1:0][TW-1:0] map_tag_q, map_tag_d;
    logic [CW-1:0]               rob_count_q, rob_count_d;
    logic [TW-1:0]               shadow_q, shadow_d;
    logic                        tail_err_q, tail_err_d;
    logic                        dispatch;
    logic                        commit_dec;
    logic [TW-1:0]               tag_b;

    // Look up one architectural source in the registered table. The commit of
    // the current cycle is deliberately not bypassed: the ROB broadcast wakes
    // the consumer instead.
    function automatic logic [TW:0] lookup(input logic [AW-1:0] r);
        return map_valid_q[r] ? {1'b1, TW'(r)} : {1'b0, map_tag_q[r]};
    endfunction

    // B reads A's destination from A itself, never from the stale table entry.
    function automatic logic [TW:0] lookup_b(input logic [AW-1:0] r);
        return (r == iq_rd_a) ? {1'b0, next_available} : lookup(r);
    endfunction

    assign iq_ready      = (rob_count_q <= CW'(ROB_DEPTH - 2));
    assign dispatch      = iq_valid && iq_ready && !reset;
    assign RAT_new_instr = dispatch;
    assign new_mul_a     = iq_mul_a;
    assign new_mul_b     = iq_mul_b;
    assign rd_a          = iq_rd_a;
    assign rd_b          = iq_rd_b;
    assign rob_count     = rob_count_q;
    assign tail_err      = tail_err_q;
    assign tag_b         = next_available + TW'(1);
    assign commit_dec    = ROB_bus_trigger && (rob_count_q != '0);

    assign {src1a_valid, src1a} = lookup(iq_rs1_a);
    assign {src2a_valid, src2a} = lookup(iq_rs2_a);
    assign {src1b_valid, src1b} = lookup_b(iq_rs1_b);
    assign {src2b_valid, src2b} = lookup_b(iq_rs2_b);

    always_comb begin
        map_valid_d = map_valid_q;
        map_tag_d   = map_tag_q;
        if (ROB_bus_trigger) begin
            for (int unsigned r = 0; r < NUM_ARCH; r++) begin
                if (!map_valid_q[r] && (map_tag_q[r] == ROB_bus_tag)) begin
                    map_valid_d[r] = 1'b1;
                end
            end
        end
        // Dispatch writes come after the commit sweep so they override it;
        // B is written last so it wins when rd_a == rd_b.
        if (dispatch) begin
            map_valid_d[iq_rd_a] = 1'b0;
            map_tag_d[iq_rd_a]   = next_available;
            map_valid_d[iq_rd_b] = 1'b0;
            map_tag_d[iq_rd_b]   = tag_b;
        end
    end

    always_comb begin
        rob_count_d = rob_count_q + (dispatch ? CW'(2) : '0) - CW'(commit_dec);
        shadow_d    = dispatch ? shadow_q + TW'(2) : shadow_q;
        tail_err_d  = tail_err_q | (dispatch && (shadow_q != next_available));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_valid_q <= '1;
            map_tag_q   <= '0;
            rob_count_q <= '0;
            shadow_q    <= '0;
            tail_err_q  <= 1'b0;
        end else begin
            map_valid_q <= map_valid_d;
            map_tag_q   <= map_tag_d;
            rob_count_q <= rob_count_d;
            shadow_q    <= shadow_d;
            tail_err_q  <= tail_err_d;
        end
    end

`ifdef RAT_STALL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (iq_valid && !iq_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rat_dual_dispatch.sv
// Directed bench for rat_dual_dispatch with hand-computed expectations.
module tb_rat_dual_dispatch;

    logic       clk = 1'b0;
    logic       reset;
    logic       iq_valid, iq_ready;
    logic       iq_mul_a, iq_mul_b;
    logic [2:0] iq_rd_a, iq_rd_b, iq_rs1_a, iq_rs2_a, iq_rs1_b, iq_rs2_b;
    logic [2:0] next_available;
    logic       ROB_bus_trigger;
    logic [2:0] ROB_bus_tag;
    logic       RAT_new_instr, new_mul_a, new_mul_b;
    logic [2:0] rd_a, rd_b, src1a, src2a, src1b, src2b;
    logic       src1a_valid, src2a_valid, src1b_valid, src2b_valid;
    logic [3:0] rob_count;
    logic       tail_err;
`ifdef RAT_STALL_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rat_dual_dispatch #(.NUM_ARCH(8), .ROB_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .iq_valid(iq_valid), .iq_ready(iq_ready),
        .iq_mul_a(iq_mul_a), .iq_mul_b(iq_mul_b),
        .iq_rd_a(iq_rd_a), .iq_rd_b(iq_rd_b),
        .iq_rs1_a(iq_rs1_a), .iq_rs2_a(iq_rs2_a),
        .iq_rs1_b(iq_rs1_b), .iq_rs2_b(iq_rs2_b),
        .next_available(next_available),
        .ROB_bus_trigger(ROB_bus_trigger), .ROB_bus_tag(ROB_bus_tag),
        .RAT_new_instr(RAT_new_instr),
        .new_mul_a(new_mul_a), .new_mul_b(new_mul_b),
        .rd_a(rd_a), .rd_b(rd_b),
        .src1a(src1a), .src2a(src2a), .src1b(src1b), .src2b(src2b),
        .src1a_valid(src1a_valid), .src2a_valid(src2a_valid),
        .src1b_valid(src1b_valid), .src2b_valid(src2b_valid),
        .rob_count(rob_count),
`ifdef RAT_STALL_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .tail_err(tail_err)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_src(input string tag, input logic [2:0] t, input logic v,
                           input logic [2:0] et, input logic ev);
        chk({tag, ".tag"}, 16'(t), 16'(et));
        chk({tag, ".v"}, 16'(v), 16'(ev));
    endtask

    task automatic drive(input logic v, input logic ma, input logic [2:0] rda,
                         input logic [2:0] s1a, input logic [2:0] s2a,
                         input logic mb, input logic [2:0] rdb,
                         input logic [2:0] s1b, input logic [2:0] s2b,
                         input logic [2:0] na);
        iq_valid = v;
        iq_mul_a = ma; iq_rd_a = rda; iq_rs1_a = s1a; iq_rs2_a = s2a;
        iq_mul_b = mb; iq_rd_b = rdb; iq_rs1_b = s1b; iq_rs2_b = s2b;
        next_available = na;
        #1;
    endtask

    task automatic commit(input logic trig, input logic [2:0] tag);
        ROB_bus_trigger = trig;
        ROB_bus_tag     = tag;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        commit(1'b0, 3'd0);
        // ADD r1<-r2,r3 / MUL r4<-r5,r6 held during reset: strobe must stay low.
        drive(1'b1, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 3'd4, 3'd5, 3'd6, 3'd0);
        chk("rst_strobe", 16'(RAT_new_instr), 16'd0);
        chk("rst_ready", 16'(iq_ready), 16'd1);
        chk("rst_count", 16'(rob_count), 16'd0);
        chk("rst_tailerr", 16'(tail_err), 16'd0);
        tick();
        reset = 1'b0;
        #1;

        // First pair, clean table.
        chk("p1_strobe", 16'(RAT_new_instr), 16'd1);
        chk("p1_mul_a", 16'(new_mul_a), 16'd0);
        chk("p1_mul_b", 16'(new_mul_b), 16'd1);
        chk("p1_rd_a", 16'(rd_a), 16'd1);
        chk("p1_rd_b", 16'(rd_b), 16'd4);
        chk_src("p1_s1a", src1a, src1a_valid, 3'd2, 1'b1);
        chk_src("p1_s2a", src2a, src2a_valid, 3'd3, 1'b1);
        chk_src("p1_s1b", src1b, src1b_valid, 3'd5, 1'b1);
        chk_src("p1_s2b", src2b, src2b_valid, 3'd6, 1'b1);
        tick();

        // Probe r1 -> tag0, r4 -> tag1.
        drive(1'b0, 1'b0, 3'd0, 3'd1, 3'd4, 1'b0, 3'd0, 3'd0, 3'd0, 3'd2);
        chk("pr1_strobe", 16'(RAT_new_instr), 16'd0);
        chk("pr1_count", 16'(rob_count), 16'd2);
        chk_src("pr1_r1", src1a, src1a_valid, 3'd0, 1'b0);
        chk_src("pr1_r4", src2a, src2a_valid, 3'd1, 1'b0);

        // r1<-r2,r3 / r5<-r1,r1 at tail 2: B forwards from A.
        drive(1'b1, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 3'd5, 3'd1, 3'd1, 3'd2);
        chk_src("p2_s1a", src1a, src1a_valid, 3'd2, 1'b1);
        chk_src("p2_fwd1", src1b, src1b_valid, 3'd2, 1'b0);
        chk_src("p2_fwd2", src2b, src2b_valid, 3'd2, 1'b0);
        tick();
        // map: r1=tag2, r4=tag1, r5=tag3; count 4; shadow 4

        // Commit tag1 (r4): same-cycle rename still reports pending.
        drive(1'b0, 1'b0, 3'd0, 3'd4, 3'd1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd4);
        commit(1'b1, 3'd1);
        chk_src("cf_r4", src1a, src1a_valid, 3'd1, 1'b0);
        chk_src("cf_r1", src2a, src2a_valid, 3'd2, 1'b0);
        tick();

        // Commit tag0 while r1 already remapped to tag2.
        commit(1'b1, 3'd0);
        chk_src("c1_r4", src1a, src1a_valid, 3'd4, 1'b1);
        chk("c1_count", 16'(rob_count), 16'd3);
        tick();

        commit(1'b1, 3'd2);
        chk_src("c0_r1", src2a, src2a_valid, 3'd2, 1'b0);
        chk("c0_count", 16'(rob_count), 16'd2);
        tick();

        commit(1'b1, 3'd3);
        chk_src("c2_r1", src2a, src2a_valid, 3'd1, 1'b1);
        chk("c2_count", 16'(rob_count), 16'd1);
        tick();

        // Spurious commit at count 0 is ignored.
        commit(1'b1, 3'd5);
        chk("c3_count", 16'(rob_count), 16'd0);
        tick();
        commit(1'b0, 3'd0);
        chk("c_empty", 16'(rob_count), 16'd0);

        // Four back-to-back pairs.
        drive(1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 3'd3, 3'd0, 3'd0, 3'd4);
        chk("f1_strobe", 16'(RAT_new_instr), 16'd1);
        tick();
        drive(1'b1, 1'b0, 3'd7, 3'd0, 3'd0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd6);
        chk("f2_count", 16'(rob_count), 16'd2);
        tick();
        // r7 must hold B's tag 7; shadow wrapped to 0.
        drive(1'b1, 1'b0, 3'd1, 3'd7, 3'd0, 1'b0, 3'd2, 3'd0, 3'd0, 3'd0);
        chk_src("f3_r7", src1a, src1a_valid, 3'd7, 1'b0);
        chk("f3_count", 16'(rob_count), 16'd4);
        tick();
        drive(1'b1, 1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 3'd4, 3'd0, 3'd0, 3'd2);
        chk("f4_count", 16'(rob_count), 16'd6);
        chk("f4_ready", 16'(iq_ready), 16'd1);
        chk("f4_strobe", 16'(RAT_new_instr), 16'd1);
        tick();
        chk("full_count", 16'(rob_count), 16'd8);
        chk("full_ready", 16'(iq_ready), 16'd0);
        chk("full_strobe", 16'(RAT_new_instr), 16'd0);
        chk("wrap_tailerr", 16'(tail_err), 16'd0);
        tick();
        tick();
        tick();
        iq_valid = 1'b0;
        #1;
        chk("hold_count", 16'(rob_count), 16'd8);
`ifdef RAT_STALL_STATS_EN
        chk("stall_cnt", stall_cnt, 16'd3);
`endif

        // Commit while full: credit arrives only a cycle later.
        iq_valid = 1'b1;
        commit(1'b1, 3'd4);
        chk("cr_ready8", 16'(iq_ready), 16'd0);
        tick();
        chk("cr_ready7", 16'(iq_ready), 16'd0);
        chk("cr_strobe7", 16'(RAT_new_instr), 16'd0);
        tick();
        iq_valid = 1'b0;
        commit(1'b0, 3'd0);
        chk("cr_count6", 16'(rob_count), 16'd6);
        chk("cr_ready6", 16'(iq_ready), 16'd1);

        // Shadow tail is 4; drive next_available=5.
        drive(1'b1, 1'b0, 3'd5, 3'd0, 3'd0, 1'b0, 3'd6, 3'd0, 3'd0, 3'd5);
        tick();
        iq_valid = 1'b0;
        #1;
        chk("terr_set", 16'(tail_err), 16'd1);
        chk("terr_count", 16'(rob_count), 16'd8);
        tick();
        chk("terr_hold", 16'(tail_err), 16'd1);

        // Asynchronous reset mid-stream.
        reset = 1'b1;
        iq_valid = 1'b1;
        #1;
        chk("ar_count", 16'(rob_count), 16'd0);
        chk("ar_tailerr", 16'(tail_err), 16'd0);
        chk("ar_ready", 16'(iq_ready), 16'd1);
        chk("ar_strobe", 16'(RAT_new_instr), 16'd0);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 3'd1, 3'd7, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        chk_src("ar_r1", src1a, src1a_valid, 3'd1, 1'b1);
        chk_src("ar_r7", src2a, src2a_valid, 3'd7, 1'b1);

        // Dispatch write overrides a same-cycle commit of the same register.
        drive(1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 3'd2, 3'd0, 3'd0, 3'd0);
        tick();
        drive(1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 3'd3, 3'd0, 3'd0, 3'd2);
        commit(1'b1, 3'd0);
        chk("ov_strobe", 16'(RAT_new_instr), 16'd1);
        tick();
        commit(1'b0, 3'd0);
        drive(1'b0, 1'b0, 3'd0, 3'd1, 3'd3, 1'b0, 3'd0, 3'd0, 3'd0, 3'd4);
        chk_src("ov_r1", src1a, src1a_valid, 3'd2, 1'b0);
        chk_src("ov_r3", src2a, src2a_valid, 3'd3, 1'b0);
        chk("ov_count", 16'(rob_count), 16'd3);
        chk("ov_tailerr", 16'(tail_err), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
